// File: rtl/trig_sequencer.sv
// rtl/trig_sequencer.sv - Queues grid rotation requests and replays them as spaced trigger pulses.
module trig_sequencer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CW-1:0]            req_x,
  input  logic [CW-1:0]            req_y,
  input  logic [1:0]               req_rot,
  input  logic                     flush,
  output logic                     trig_en,
  output logic [CW-1:0]            trig_x,
  output logic [CW-1:0]            trig_y,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int EW = 2 * CW + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PULSE  = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;

  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      state_q, state_d;
  logic [1:0]      rem_q, rem_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [CW-1:0]   cur_x_q, cur_x_d;
  logic [CW-1:0]   cur_y_q, cur_y_d;

  logic            full;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  assign full = (level_q == (AW+1)'(DEPTH));
  assign head = fifo_mem[rd_ptr_q];
  // Zero-rotation requests are acknowledged but never stored.
  assign push = req_valid && !full && !flush && (req_rot != 2'd0);
  assign pop  = (state_q == IDLE) && (level_q != '0) && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    rem_d      = rem_q;
    gcnt_d     = gcnt_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (req_valid && full) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_x_d = head[EW-1 -: CW];
          cur_y_d = head[CW+1 -: CW];
          rem_d   = head[1:0];
          state_d = PULSE;
        end
      end
      PULSE: begin
        rem_d = rem_q - 2'd1;
        if (GAP > 0) begin
          state_d = ST_GAP;
          gcnt_d  = GW'(GAP - 1);
        end else if (rem_q > 2'd1) begin
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) state_d = (rem_q != 2'd0) ? PULSE : IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
      rem_d      = 2'd0;
      gcnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {req_x, req_y, req_rot};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      rem_q      <= 2'd0;
      gcnt_q     <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      gcnt_q     <= gcnt_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
    end
  end

  // Pulse outputs decode straight from registers so the grid never sees glitches.
  assign trig_en   = (state_q == PULSE);
  assign trig_x    = trig_en ? cur_x_q : '0;
  assign trig_y    = trig_en ? cur_y_q : '0;
  assign busy      = (state_q != IDLE) || (level_q != '0);
  assign overflow  = overflow_q;
  assign level     = level_q;
  assign req_ready = !full;

endmodule
